// File: rtl/instr_mem_seq_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_seq_pkg
// Shared defaults and FSM state encoding for the nibble-cell instruction
// memory (instr_mem_seq) and its cell array (imem_cell_array).
//   WORD_LEN_DEF   : default instruction width in bits
//   MEM_CELL_SIZE  : default storage cell width in bits
//   INSTR_MEM_SIZE : default number of cells (power of two)
//   ADDR_W_DEF     : default PC / cell address width
//   imem_state_t   : IMEM_IDLE / IMEM_READ / IMEM_RESP
// ---------------------------------------------------------------------------
package instr_mem_seq_pkg;

  localparam int WORD_LEN_DEF   = 16;
  localparam int MEM_CELL_SIZE  = 4;
  localparam int INSTR_MEM_SIZE = 1024;
  localparam int ADDR_W_DEF     = 16;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_READ = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_t;

endpackage

// File: rtl/instr_mem_seq_imem_cell_array.sv
// ---------------------------------------------------------------------------
// imem_cell_array
// DEPTH x CELL_W cell RAM: one synchronous write port, one combinational
// read port. Contents are never reset; they persist across rst and are X
// until written.
// Ports:
//   clk     in  rising-edge clock
//   wr_en   in  write strobe (already qualified by the caller)
//   wr_idx  in  IDX_W  write cell index
//   wr_data in  CELL_W write data
//   rd_idx  in  IDX_W  read cell index
//   rd_data out CELL_W cell at rd_idx (combinational)
// ---------------------------------------------------------------------------
module imem_cell_array
  import instr_mem_seq_pkg::*;
#(
  parameter int CELL_W = MEM_CELL_SIZE,
  parameter int DEPTH  = INSTR_MEM_SIZE,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [CELL_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [CELL_W-1:0] rd_data
);

  logic [CELL_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instr_mem_seq.sv
// ---------------------------------------------------------------------------
// instr_mem_seq
// Loadable instruction memory built from CELL_W-bit cells. A fetch request
// (valid/ready) is served by reading CELLS consecutive cells, one per cycle,
// and assembling them big-endian (lowest address ends up in the MSBs).
// The load port writes one cell per cycle while the fetch FSM is idle.
//
// Optional build macro: IMEM_BOUNDS_CHECK_EN
//   defined   : fetches whose last cell lies at or beyond DEPTH return a NOP
//               (all zeros) with rsp_fault=1; loads with ld_addr >= DEPTH
//               are dropped.
//   undefined : all addresses wrap modulo DEPTH, rsp_fault stays 0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   fetch request handshake, req_addr = first cell
//   rsp_valid/rsp_ready   response handshake; rsp_instr, rsp_addr (echo of
//                         req_addr), rsp_fault held stable until taken
//   ld_en/ld_addr/ld_data cell write port (ignored while busy)
//   busy                  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module instr_mem_seq
  import instr_mem_seq_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int CELL_W   = MEM_CELL_SIZE,
  parameter int DEPTH    = INSTR_MEM_SIZE,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORD_LEN-1:0] rsp_instr,
  output logic [ADDR_W-1:0]   rsp_addr,
  output logic                rsp_fault,
  input  logic                ld_en,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [CELL_W-1:0]   ld_data,
  output logic                busy
);

  localparam int CELLS = WORD_LEN / CELL_W;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(CELLS) + 1;

  imem_state_t         state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [IDX_W-1:0]    base_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [WORD_LEN-1:0] shreg_reg;
  logic                fault_reg;
  logic                rsp_valid_reg;
  logic [WORD_LEN-1:0] rsp_instr_reg;
  logic [ADDR_W-1:0]   rsp_addr_reg;
  logic                rsp_fault_reg;

  logic                accept;
  logic                last_read;
  logic                fault_calc;
  logic                ld_in_range;
  logic                mem_wr_en;
  logic [IDX_W-1:0]    rd_idx;
  logic [CELL_W-1:0]   rd_data;
  logic [WORD_LEN-1:0] shreg_shifted;

  // Upper load-address bits only matter when bounds checking is built in.
  logic unused_ld_hi;
  assign unused_ld_hi = &{1'b0, ld_addr[ADDR_W-1:IDX_W]};

`ifdef IMEM_BOUNDS_CHECK_EN
  logic [ADDR_W:0] last_cell_addr;
  assign last_cell_addr = {1'b0, req_addr} + (ADDR_W+1)'(CELLS - 1);
  assign fault_calc     = (last_cell_addr >= (ADDR_W+1)'(DEPTH));
  assign ld_in_range    = ({1'b0, ld_addr} < (ADDR_W+1)'(DEPTH));
`else
  assign fault_calc  = 1'b0;
  assign ld_in_range = 1'b1;
`endif

  assign accept    = req_valid && req_ready;
  assign last_read = (cnt_reg == CNT_W'(CELLS - 1));

  // Index addition truncates to IDX_W bits, giving the modulo-DEPTH wrap.
  assign rd_idx        = base_reg + IDX_W'(cnt_reg);
  assign shreg_shifted = (shreg_reg << CELL_W) | WORD_LEN'(rd_data);

  // Loads are only honoured while idle; outside IDLE they are dropped.
  assign mem_wr_en = ld_en && (state_reg == IMEM_IDLE) && !rst && ld_in_range;

  imem_cell_array #(
    .CELL_W (CELL_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_cells (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_idx  (ld_addr[IDX_W-1:0]),
    .wr_data (ld_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IMEM_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IMEM_IDLE: if (accept) state_next = IMEM_READ;
      IMEM_READ: if (last_read) state_next = IMEM_RESP;
      IMEM_RESP: begin
        if (rsp_ready) begin
          state_next = accept ? IMEM_READ : IMEM_IDLE;
        end
      end
      default:   state_next = IMEM_IDLE;
    endcase
  end

  // FSM: outputs. A load in the same cycle always beats a fetch request.
  always_comb begin
    busy      = (state_reg != IMEM_IDLE);
    req_ready = !rst && !ld_en &&
                ((state_reg == IMEM_IDLE) ||
                 ((state_reg == IMEM_RESP) && rsp_ready));
  end

  // Datapath: counter, shift register, latched request and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      base_reg      <= '0;
      addr_reg      <= '0;
      shreg_reg     <= '0;
      fault_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_instr_reg <= '0;
      rsp_addr_reg  <= '0;
      rsp_fault_reg <= 1'b0;
    end else begin
      if (accept) begin
        base_reg  <= req_addr[IDX_W-1:0];
        addr_reg  <= req_addr;
        shreg_reg <= '0;
        cnt_reg   <= '0;
        fault_reg <= fault_calc;
      end else if (state_reg == IMEM_READ) begin
        shreg_reg <= shreg_shifted;
        cnt_reg   <= cnt_reg + 1'b1;
        if (last_read) begin
          // Faulting fetches still spend CELLS cycles, then return a NOP.
          rsp_instr_reg <= fault_reg ? '0 : shreg_shifted;
          rsp_addr_reg  <= addr_reg;
          rsp_fault_reg <= fault_reg;
          rsp_valid_reg <= 1'b1;
        end
      end

      if ((state_reg == IMEM_RESP) && rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_instr = rsp_instr_reg;
  assign rsp_addr  = rsp_addr_reg;
  assign rsp_fault = rsp_fault_reg;

endmodule
